// File: rtl/arb_rd_from_sram_pkg.sv
// Shared definitions for the SRAM read arbiter: FSM encodings, requester
// class codes and the default read-data width.
package arb_rd_from_sram_pkg;

  localparam int DATA_W_DEF = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_READ = 2'b11,
    ST_DONE = 2'b10
  } state_t;

  // Class code doubles as the requester index and as Rd_ID[5:4].
  typedef enum logic [1:0] {
    CLS_WEI    = 2'b00,
    CLS_WEIFLG = 2'b01,
    CLS_ACT    = 2'b10,
    CLS_ACTFLG = 2'b11
  } cls_t;

  // First class to try in the rotating group; "none" behaves like ActFlg.
  function automatic logic [1:0] rot_start(input cls_t last, input logic last_vld);
    logic [1:0] start;
    start = CLS_WEIFLG;
    if (last_vld) begin
      case (last)
        CLS_WEIFLG: start = CLS_ACT;
        CLS_ACT:    start = CLS_ACTFLG;
        default:    start = CLS_WEIFLG;
      endcase
    end
    return start;
  endfunction

endpackage

// File: rtl/arb_rd_from_sram_if.sv
// Bundle of requester-side and SRAM-side read signals around the arbiter.
interface arb_rd_from_sram_if
  import arb_rd_from_sram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    // Rd_Req_x are levels held until the matching one-cycle Rd_Done_x; Rd_Req
    // stays high until a one-cycle Rd_Gnt; each Rd_Dat_Vld_In/Rd_Vld_x cycle is one beat.
    logic              Rd_Req_Wei, Rd_Req_WeiFlg, Rd_Req_Act, Rd_Req_ActFlg;
    logic [5:0]        Rd_ID_Wei, Rd_ID_WeiFlg, Rd_ID_Act, Rd_ID_ActFlg;
    logic [3:0]        Rd_Len_Wei, Rd_Len_WeiFlg, Rd_Len_Act, Rd_Len_ActFlg;
    logic              Rd_Gnt;
    logic [DATA_W-1:0] Rd_Dat_In;
    logic              Rd_Dat_Vld_In;
    logic              Rd_Req;
    logic [5:0]        Rd_ID;
    logic [DATA_W-1:0] Rd_Dat;
    logic              Rd_Vld_Wei, Rd_Vld_WeiFlg, Rd_Vld_Act, Rd_Vld_ActFlg;
    logic              Rd_Done_Wei, Rd_Done_WeiFlg, Rd_Done_Act, Rd_Done_ActFlg;
    logic [1:0]        State_Rd;

    modport slave (
        input  Rd_Req_Wei, Rd_Req_WeiFlg, Rd_Req_Act, Rd_Req_ActFlg,
        input  Rd_ID_Wei, Rd_ID_WeiFlg, Rd_ID_Act, Rd_ID_ActFlg,
        input  Rd_Len_Wei, Rd_Len_WeiFlg, Rd_Len_Act, Rd_Len_ActFlg,
        input  Rd_Gnt, Rd_Dat_In, Rd_Dat_Vld_In,
        output Rd_Req, Rd_ID, Rd_Dat,
        output Rd_Vld_Wei, Rd_Vld_WeiFlg, Rd_Vld_Act, Rd_Vld_ActFlg,
        output Rd_Done_Wei, Rd_Done_WeiFlg, Rd_Done_Act, Rd_Done_ActFlg,
        output State_Rd
    );

    modport master (
        output Rd_Req_Wei, Rd_Req_WeiFlg, Rd_Req_Act, Rd_Req_ActFlg,
        output Rd_ID_Wei, Rd_ID_WeiFlg, Rd_ID_Act, Rd_ID_ActFlg,
        output Rd_Len_Wei, Rd_Len_WeiFlg, Rd_Len_Act, Rd_Len_ActFlg,
        output Rd_Gnt, Rd_Dat_In, Rd_Dat_Vld_In,
        input  Rd_Req, Rd_ID, Rd_Dat,
        input  Rd_Vld_Wei, Rd_Vld_WeiFlg, Rd_Vld_Act, Rd_Vld_ActFlg,
        input  Rd_Done_Wei, Rd_Done_WeiFlg, Rd_Done_Act, Rd_Done_ActFlg,
        input  State_Rd
    );

endinterface

// File: rtl/arb_rd_rr_sel.sv
// Combinational requester select: Wei has fixed top priority, the other three
// classes rotate starting after the last served one. Output is one-hot.
module arb_rd_rr_sel
  import arb_rd_from_sram_pkg::*;
(
    input  logic [3:0] req,
    input  cls_t       last_cls,
    input  logic       last_vld,
    output logic [3:0] gnt
);

    logic [1:0] idx;

    always_comb begin
        gnt = '0;
        idx = rot_start(last_cls, last_vld);
        if (req[CLS_WEI]) begin
            gnt[CLS_WEI] = 1'b1;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (gnt == 4'b0000 && req[idx]) gnt[idx] = 1'b1;
                idx = (idx == CLS_ACTFLG) ? 2'(CLS_WEIFLG) : idx + 2'd1;
            end
        end
    end

endmodule

// File: rtl/arb_rd_from_sram.sv
// Four-requester SRAM read arbiter: picks one requester, issues Rd_Req/Rd_ID,
// then steers the registered read beats and a done pulse to the owner.
module arb_rd_from_sram
  import arb_rd_from_sram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input logic               clk,
    input logic               rst_n,
    arb_rd_from_sram_if.slave bus
);

    state_t            state_q, state_d;
    cls_t              owner_q, win_cls;
    cls_t              last_q;
    logic              last_vld_q;
    logic [5:0]        id_q, win_id;
    logic [3:0]        len_q, win_len, cnt_q;
    logic [3:0]        req_vec, gnt, vld_q, done_vec;
    logic [DATA_W-1:0] dat_q;
    logic              beat, last_beat;

    assign req_vec = {bus.Rd_Req_ActFlg, bus.Rd_Req_Act, bus.Rd_Req_WeiFlg, bus.Rd_Req_Wei};

    arb_rd_rr_sel u_sel (
        .req      (req_vec),
        .last_cls (last_q),
        .last_vld (last_vld_q),
        .gnt      (gnt)
    );

    always_comb begin
        win_cls = CLS_WEI;
        win_id  = bus.Rd_ID_Wei;
        win_len = bus.Rd_Len_Wei;
        if (gnt[CLS_WEIFLG]) begin
            win_cls = CLS_WEIFLG;
            win_id  = bus.Rd_ID_WeiFlg;
            win_len = bus.Rd_Len_WeiFlg;
        end else if (gnt[CLS_ACT]) begin
            win_cls = CLS_ACT;
            win_id  = bus.Rd_ID_Act;
            win_len = bus.Rd_Len_Act;
        end else if (gnt[CLS_ACTFLG]) begin
            win_cls = CLS_ACTFLG;
            win_id  = bus.Rd_ID_ActFlg;
            win_len = bus.Rd_Len_ActFlg;
        end
    end

    // Beats only count while in READ, so stray valids around the grant are dropped.
    assign beat      = (state_q == ST_READ) && bus.Rd_Dat_Vld_In;
    assign last_beat = beat && (cnt_q == len_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (|req_vec) state_d = ST_REQ;
            ST_REQ:  if (bus.Rd_Gnt) state_d = ST_READ;
            ST_READ: if (last_beat) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            owner_q    <= CLS_WEI;
            id_q       <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            last_q     <= CLS_ACTFLG;
            last_vld_q <= 1'b0;
            vld_q      <= '0;
            dat_q      <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && |req_vec) begin
                owner_q <= win_cls;
                id_q    <= win_id;
                len_q   <= win_len;
            end
            if (beat) cnt_q <= cnt_q + 4'd1;
            else if (state_q != ST_READ) cnt_q <= '0;
            // Wei never moves the rotation pointer.
            if (state_q == ST_DONE && owner_q != CLS_WEI) begin
                last_q     <= owner_q;
                last_vld_q <= 1'b1;
            end
            vld_q <= beat ? (4'b0001 << owner_q) : 4'b0000;
            if (beat) dat_q <= bus.Rd_Dat_In;
        end
    end

    // DONE follows the last accepted beat, so the done pulse lines up with its registered valid.
    assign done_vec = (state_q == ST_DONE) ? (4'b0001 << owner_q) : 4'b0000;

    assign bus.Rd_Req         = (state_q == ST_REQ);
    assign bus.Rd_ID          = id_q;
    assign bus.Rd_Dat         = dat_q;
    assign bus.Rd_Vld_Wei     = vld_q[CLS_WEI];
    assign bus.Rd_Vld_WeiFlg  = vld_q[CLS_WEIFLG];
    assign bus.Rd_Vld_Act     = vld_q[CLS_ACT];
    assign bus.Rd_Vld_ActFlg  = vld_q[CLS_ACTFLG];
    assign bus.Rd_Done_Wei    = done_vec[CLS_WEI];
    assign bus.Rd_Done_WeiFlg = done_vec[CLS_WEIFLG];
    assign bus.Rd_Done_Act    = done_vec[CLS_ACT];
    assign bus.Rd_Done_ActFlg = done_vec[CLS_ACTFLG];
    assign bus.State_Rd       = state_q;

endmodule

// File: tb/tb_arb_rd_from_sram.sv
// Directed bench for the SRAM read arbiter: one task per scenario, inputs
// driven and outputs sampled on the falling clock edge.
module tb_arb_rd_from_sram;

  localparam int DW = 128;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;

  arb_rd_from_sram_if #(.DATA_W(DW)) bus ();

  arb_rd_from_sram #(.DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [3:0] vld_vec();
    return {bus.Rd_Vld_ActFlg, bus.Rd_Vld_Act, bus.Rd_Vld_WeiFlg, bus.Rd_Vld_Wei};
  endfunction

  function automatic logic [3:0] done_vec();
    return {bus.Rd_Done_ActFlg, bus.Rd_Done_Act, bus.Rd_Done_WeiFlg, bus.Rd_Done_Wei};
  endfunction

  task automatic clear_inputs();
    bus.Rd_Req_Wei = 0; bus.Rd_Req_WeiFlg = 0; bus.Rd_Req_Act = 0; bus.Rd_Req_ActFlg = 0;
    bus.Rd_ID_Wei = '0; bus.Rd_ID_WeiFlg = '0; bus.Rd_ID_Act = '0; bus.Rd_ID_ActFlg = '0;
    bus.Rd_Len_Wei = '0; bus.Rd_Len_WeiFlg = '0; bus.Rd_Len_Act = '0; bus.Rd_Len_ActFlg = '0;
    bus.Rd_Gnt = 0; bus.Rd_Dat_In = '0; bus.Rd_Dat_Vld_In = 0;
  endtask

  task automatic set_req(input int cls, input logic on, input logic [5:0] id, input logic [3:0] len);
    case (cls)
      0: begin bus.Rd_Req_Wei = on;    bus.Rd_ID_Wei = id;    bus.Rd_Len_Wei = len;    end
      1: begin bus.Rd_Req_WeiFlg = on; bus.Rd_ID_WeiFlg = id; bus.Rd_Len_WeiFlg = len; end
      2: begin bus.Rd_Req_Act = on;    bus.Rd_ID_Act = id;    bus.Rd_Len_Act = len;    end
      default: begin bus.Rd_Req_ActFlg = on; bus.Rd_ID_ActFlg = id; bus.Rd_Len_ActFlg = len; end
    endcase
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Waits (bounded) for REQ, grants, sends len+1 back-to-back beats; returns
  // what was seen on the final beat's falling edge.
  task automatic serve_one(input int len, output logic ok, output int waits,
                           output logic [5:0] id_seen, output logic [3:0] done_seen,
                           output logic [3:0] vld_seen);
    ok = 1'b0; waits = 0; id_seen = '0; done_seen = '0; vld_seen = '0;
    while (bus.State_Rd != 2'b01 && waits < 20) begin
      tick();
      waits++;
    end
    if (bus.State_Rd != 2'b01) return;
    id_seen = bus.Rd_ID;
    bus.Rd_Gnt = 1'b1;
    tick();
    bus.Rd_Gnt = 1'b0;
    for (int b = 0; b <= len; b++) begin
      bus.Rd_Dat_Vld_In = 1'b1;
      bus.Rd_Dat_In = DW'(32'h100 + b);
      tick();
    end
    bus.Rd_Dat_Vld_In = 1'b0;
    done_seen = done_vec();
    vld_seen = vld_vec();
    ok = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    n_checks++; if (bus.State_Rd !== 2'b00) begin n_fail++; $display("FAIL reset_state got %b want 00", bus.State_Rd); end
    n_checks++; if (bus.Rd_Req !== 1'b0 || bus.Rd_ID !== 6'h00) begin n_fail++; $display("FAIL reset_req_id got req=%b id=%h want 0/00", bus.Rd_Req, bus.Rd_ID); end
    n_checks++; if (bus.Rd_Dat !== '0) begin n_fail++; $display("FAIL reset_dat got %h want 0", bus.Rd_Dat); end
    n_checks++; if (vld_vec() !== 4'b0 || done_vec() !== 4'b0) begin n_fail++; $display("FAIL reset_vld_done got %b/%b want 0000/0000", vld_vec(), done_vec()); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_wei();
    logic [31:0] w;
    logic [DW-1:0] exp_dat;
    set_req(0, 1'b1, 6'h05, 4'd3);
    tick();
    n_checks++; if (bus.State_Rd !== 2'b01 || bus.Rd_Req !== 1'b1 || bus.Rd_ID !== 6'h05) begin n_fail++; $display("FAIL wei_req got st=%b req=%b id=%h want 01/1/05", bus.State_Rd, bus.Rd_Req, bus.Rd_ID); end
    tick();
    n_checks++; if (bus.Rd_Req !== 1'b1 || bus.Rd_ID !== 6'h05) begin n_fail++; $display("FAIL wei_req_hold got req=%b id=%h want 1/05", bus.Rd_Req, bus.Rd_ID); end
    bus.Rd_Gnt = 1'b1;
    tick();
    bus.Rd_Gnt = 1'b0;
    n_checks++; if (bus.State_Rd !== 2'b11 || bus.Rd_Req !== 1'b0) begin n_fail++; $display("FAIL wei_read got st=%b req=%b want 11/0", bus.State_Rd, bus.Rd_Req); end
    for (int k = 0; k < 4; k++) begin
      w = 32'hA0 + k;
      exp_dat = {4{w}};
      bus.Rd_Dat_Vld_In = 1'b1;
      bus.Rd_Dat_In = exp_dat;
      tick();
      n_checks++; if (vld_vec() !== 4'b0001 || bus.Rd_Dat !== exp_dat) begin n_fail++; $display("FAIL wei_beat%0d got vld=%b dat=%h want 0001 %h", k, vld_vec(), bus.Rd_Dat, exp_dat); end
      n_checks++; if (done_vec() !== ((k == 3) ? 4'b0001 : 4'b0000)) begin n_fail++; $display("FAIL wei_done%0d got %b", k, done_vec()); end
    end
    bus.Rd_Dat_Vld_In = 1'b0;
    set_req(0, 1'b0, 6'h05, 4'd3);
    tick();
    n_checks++; if (bus.State_Rd !== 2'b00 || vld_vec() !== 4'b0 || done_vec() !== 4'b0) begin n_fail++; $display("FAIL wei_idle got st=%b vld=%b done=%b want 00/0000/0000", bus.State_Rd, vld_vec(), done_vec()); end
  endtask

  task automatic test_rotation();
    logic [1:0] exp_cls [4] = '{2'd1, 2'd2, 2'd3, 2'd1};
    logic ok;
    int waits;
    logic [5:0] id_seen;
    logic [3:0] done_seen, vld_seen;
    do_reset();
    set_req(1, 1'b1, 6'h1A, 4'd0);
    set_req(2, 1'b1, 6'h2B, 4'd0);
    set_req(3, 1'b1, 6'h3C, 4'd0);
    for (int t = 0; t < 4; t++) begin
      serve_one(0, ok, waits, id_seen, done_seen, vld_seen);
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rot_timeout%0d got no REQ want REQ", t); end
      n_checks++; if (id_seen[5:4] !== exp_cls[t]) begin n_fail++; $display("FAIL rot_id%0d got %b want %b", t, id_seen[5:4], exp_cls[t]); end
      n_checks++; if (done_seen !== (4'b0001 << exp_cls[t]) || vld_seen !== done_seen) begin n_fail++; $display("FAIL rot_done%0d got done=%b vld=%b", t, done_seen, vld_seen); end
      if (t > 0) begin
        n_checks++; if (waits !== 2) begin n_fail++; $display("FAIL rot_gap%0d got %0d want 2", t, waits); end
      end
    end
    clear_inputs();
    tick();
    tick();
    n_checks++; if (bus.State_Rd !== 2'b00) begin n_fail++; $display("FAIL rot_idle got %b want 00", bus.State_Rd); end
  endtask

  task automatic test_wei_priority();
    logic ok;
    int waits;
    logic [5:0] id_seen;
    logic [3:0] done_seen, vld_seen;
    do_reset();
    set_req(1, 1'b1, 6'h11, 4'd0);
    serve_one(0, ok, waits, id_seen, done_seen, vld_seen);
    n_checks++; if (ok !== 1'b1 || done_seen !== 4'b0010) begin n_fail++; $display("FAIL pri_first got ok=%b done=%b want 1/0010", ok, done_seen); end
    // Pointer now after WeiFlg: Wei first, then Act, then WeiFlg.
    set_req(0, 1'b1, 6'h07, 4'd0);
    set_req(2, 1'b1, 6'h22, 4'd0);
    set_req(1, 1'b1, 6'h13, 4'd0);
    serve_one(0, ok, waits, id_seen, done_seen, vld_seen);
    n_checks++; if (ok !== 1'b1 || id_seen !== 6'h07 || done_seen !== 4'b0001) begin n_fail++; $display("FAIL pri_wei got id=%h done=%b want 07/0001", id_seen, done_seen); end
    set_req(0, 1'b0, 6'h07, 4'd0);
    serve_one(0, ok, waits, id_seen, done_seen, vld_seen);
    n_checks++; if (ok !== 1'b1 || id_seen !== 6'h22 || done_seen !== 4'b0100) begin n_fail++; $display("FAIL pri_act got id=%h done=%b want 22/0100", id_seen, done_seen); end
    set_req(2, 1'b0, 6'h22, 4'd0);
    serve_one(0, ok, waits, id_seen, done_seen, vld_seen);
    n_checks++; if (ok !== 1'b1 || id_seen !== 6'h13 || done_seen !== 4'b0010) begin n_fail++; $display("FAIL pri_weiflg got id=%h done=%b want 13/0010", id_seen, done_seen); end
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_ignore_vld();
    do_reset();
    bus.Rd_Dat_Vld_In = 1'b1;
    tick();
    bus.Rd_Dat_Vld_In = 1'b0;
    n_checks++; if (vld_vec() !== 4'b0 || bus.State_Rd !== 2'b00) begin n_fail++; $display("FAIL ign_idle got vld=%b st=%b want 0000/00", vld_vec(), bus.State_Rd); end
    set_req(0, 1'b1, 6'h09, 4'd1);
    tick();
    bus.Rd_Gnt = 1'b1;
    bus.Rd_Dat_Vld_In = 1'b1;
    tick();
    bus.Rd_Gnt = 1'b0;
    bus.Rd_Dat_Vld_In = 1'b0;
    n_checks++; if (vld_vec() !== 4'b0 || bus.State_Rd !== 2'b11) begin n_fail++; $display("FAIL ign_gnt got vld=%b st=%b want 0000/11", vld_vec(), bus.State_Rd); end
    bus.Rd_Dat_Vld_In = 1'b1;
    tick();
    n_checks++; if (vld_vec() !== 4'b0001 || done_vec() !== 4'b0 || bus.State_Rd !== 2'b11) begin n_fail++; $display("FAIL ign_beat1 got vld=%b done=%b st=%b want 0001/0000/11", vld_vec(), done_vec(), bus.State_Rd); end
    tick();
    bus.Rd_Dat_Vld_In = 1'b0;
    n_checks++; if (done_vec() !== 4'b0001) begin n_fail++; $display("FAIL ign_beat2 got done=%b want 0001", done_vec()); end
    set_req(0, 1'b0, 6'h09, 4'd1);
    tick();
  endtask

  task automatic test_len15_reset();
    logic ok;
    int waits;
    logic [5:0] id_seen;
    logic [3:0] done_seen, vld_seen;
    int bad_done;
    bad_done = 0;
    set_req(3, 1'b1, 6'h3F, 4'd15);
    tick();
    n_checks++; if (bus.State_Rd !== 2'b01 || bus.Rd_ID !== 6'h3F) begin n_fail++; $display("FAIL l15_req got st=%b id=%h want 01/3f", bus.State_Rd, bus.Rd_ID); end
    bus.Rd_Gnt = 1'b1;
    tick();
    bus.Rd_Gnt = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bus.Rd_Dat_Vld_In = 1'b1;
      bus.Rd_Dat_In = DW'(32'h7700 + k);
      tick();
      if (done_vec() !== 4'b0) bad_done++;
    end
    n_checks++; if (bad_done !== 0 || vld_vec() !== 4'b1000) begin n_fail++; $display("FAIL l15_beats got early_done=%0d vld=%b want 0/1000", bad_done, vld_vec()); end
    clear_inputs();
    rst_n = 1'b0;
    tick();
    n_checks++; if (bus.State_Rd !== 2'b00 || bus.Rd_Req !== 1'b0 || bus.Rd_ID !== 6'h00) begin n_fail++; $display("FAIL l15_rst_ctl got st=%b req=%b id=%h want 00/0/00", bus.State_Rd, bus.Rd_Req, bus.Rd_ID); end
    n_checks++; if (bus.Rd_Dat !== '0 || vld_vec() !== 4'b0 || done_vec() !== 4'b0) begin n_fail++; $display("FAIL l15_rst_dat got dat=%h vld=%b done=%b want 0", bus.Rd_Dat, vld_vec(), done_vec()); end
    rst_n = 1'b1;
    tick();
    set_req(3, 1'b1, 6'h30, 4'd0);
    serve_one(0, ok, waits, id_seen, done_seen, vld_seen);
    n_checks++; if (ok !== 1'b1 || done_seen !== 4'b1000 || vld_seen !== 4'b1000) begin n_fail++; $display("FAIL l15_after got ok=%b done=%b vld=%b want 1/1000/1000", ok, done_seen, vld_seen); end
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_gapped();
    logic [4:0] pat;
    pat = 5'b11001;
    set_req(2, 1'b1, 6'h2A, 4'd2);
    tick();
    bus.Rd_Gnt = 1'b1;
    tick();
    bus.Rd_Gnt = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.Rd_Dat_Vld_In = pat[k];
      bus.Rd_Dat_In = DW'(32'h5500 + k);
      tick();
      n_checks++; if (vld_vec() !== (pat[k] ? 4'b0100 : 4'b0000)) begin n_fail++; $display("FAIL gap_vld%0d got %b want %b", k, vld_vec(), pat[k] ? 4'b0100 : 4'b0000); end
      n_checks++; if (done_vec() !== ((k == 4) ? 4'b0100 : 4'b0000)) begin n_fail++; $display("FAIL gap_done%0d got %b", k, done_vec()); end
    end
    bus.Rd_Dat_Vld_In = 1'b0;
    clear_inputs();
    tick();
    n_checks++; if (bus.State_Rd !== 2'b00) begin n_fail++; $display("FAIL gap_idle got %b want 00", bus.State_Rd); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_wei();
    test_rotation();
    test_wei_priority();
    test_ignore_vld();
    test_len15_reset();
    test_gapped();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
